irq_vec: RTL and testbench

Vectored interrupt responder on the 65C02 core's memory bus. It latches up to eight edge-triggered interrupt sources, masks and prioritises them, and drives the core's `irq` input. It answers register reads and writes in a small I/O window. When an unmasked interrupt is pending, it substitutes a per-source vector for the core's FFFE/FFFF vector fetch. It is a bus target beside RAM; its read data is muxed onto the core's DB by `sel`.

---
 rtl/irq_vec_pkg.sv | 25 ++
 rtl/irq_prio.sv | 20 ++
 rtl/irq_vec.sv | 113 +++++++++++
 tb/tb_irq_vec.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/irq_vec_pkg.sv
// Shared constants, state encoding and vector arithmetic for the irq_vec interrupt responder.
package irq_vec_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned IDX_W  = 3;

  localparam logic [ADDR_W-1:0] REG_STATUS = 16'd0;
  localparam logic [ADDR_W-1:0] REG_MASK   = 16'd1;
  localparam logic [ADDR_W-1:0] REG_INDEX  = 16'd2;

  localparam logic [DATA_W-1:0] IDX_NONE = 8'h80;

  localparam logic [ADDR_W-1:0] VEC_LO = 16'hFFFE;
  localparam logic [ADDR_W-1:0] VEC_HI = 16'hFFFF;

  typedef enum logic {IDLE, LO} state_t;

  // 16-bit vector address for a source; wraps modulo 2^16 so both bytes share one carry chain.
  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] vbase,
                                                 input logic [IDX_W-1:0]  vidx);
    return vbase + {11'd0, vidx, 2'b00};
  endfunction

endpackage

// File: rtl/irq_prio.sv
// Combinational priority encoder: lowest set request bit wins; idx is 0 when nothing is set.
module irq_prio
  import irq_vec_pkg::*;
#(
  parameter int unsigned NSRC = 8
) (
  input  logic [NSRC-1:0]  req,
  output logic [IDX_W-1:0] idx,
  output logic             none
);

  always_comb begin
    idx  = '0;
    none = ~|req;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_vec.sv
// Vectored interrupt responder: edge-latched sources, mask/priority, register window and FFFE/FFFF vector substitution.
// Optional IRQ_VEC_AUTOACK_EN: the served FFFF fetch clears the pending bit of the vectored source.
module irq_vec
  import irq_vec_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE     = 16'hFE00,
  parameter logic [ADDR_W-1:0] VEC_BASE = 16'hFF00,
  parameter int unsigned       NSRC     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] AB,
  input  logic              WE,
  input  logic [DATA_W-1:0] DO,
  input  logic [NSRC-1:0]   src,
  output logic              irq,
  output logic [DATA_W-1:0] DI,
  output logic              sel
);

  logic [NSRC-1:0]   src_q, pend, mask, rise, act, ack, clr;
  logic [IDX_W-1:0]  idx, vidx, vidx_d, vsel;
  logic              none;
  logic [ADDR_W-1:0] vsum;
  logic [DATA_W-1:0] di_d, index_val;
  logic              sel_d;
  logic              rd, rd_lo, rd_hi, hit_status, hit_mask, hit_index;
  state_t            state, state_d;

  assign rise       = src & ~src_q;
  assign act        = pend & mask;
  assign rd         = ~WE;
  assign hit_status = (AB == BASE + REG_STATUS);
  assign hit_mask   = (AB == BASE + REG_MASK);
  assign hit_index  = (AB == BASE + REG_INDEX);
  assign rd_lo      = rd && (AB == VEC_LO);
  assign rd_hi      = rd && (AB == VEC_HI);

  irq_prio #(.NSRC(NSRC)) u_prio (
    .req  (act),
    .idx  (idx),
    .none (none)
  );

  assign index_val = none ? IDX_NONE : DATA_W'(idx);

  // High byte uses the frozen index; a new fetch uses the live one.
  assign vsel = (state == LO && rd_hi) ? vidx : idx;
  assign vsum = vec_addr(VEC_BASE, vsel);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus the registered bus response for this cycle.
  always_comb begin
    state_d = IDLE;
    vidx_d  = vidx;
    sel_d   = 1'b0;
    di_d    = '0;
    if (state == LO && rd_hi) begin
      sel_d = 1'b1;
      di_d  = vsum[15:8];
    end else if (rd_lo && irq) begin
      state_d = LO;
      vidx_d  = idx;
      sel_d   = 1'b1;
      di_d    = vsum[7:0];
    end else if (rd && hit_status) begin
      sel_d = 1'b1;
      di_d  = DATA_W'(pend);
    end else if (rd && hit_mask) begin
      sel_d = 1'b1;
      di_d  = DATA_W'(mask);
    end else if (rd && hit_index) begin
      sel_d = 1'b1;
      di_d  = index_val;
    end
  end

  always_comb begin
    ack = '0;
`ifdef IRQ_VEC_AUTOACK_EN
    for (int i = 0; i < int'(NSRC); i++) begin
      ack[i] = (state == LO) && rd_hi && (vidx == IDX_W'(i));
    end
`endif
  end

  assign clr = ((WE && hit_status) ? DO[NSRC-1:0] : '0) | ack;

  // src_q tracks src even in reset so release never produces a false edge.
  always_ff @(posedge clk) begin
    src_q <= src;
    if (!reset) begin
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
      vidx <= '0;
      DI   <= '0;
      sel  <= 1'b0;
    end else begin
      pend <= (pend & ~clr) | rise;
      if (WE && hit_mask) mask <= DO[NSRC-1:0];
      irq  <= |act;
      vidx <= vidx_d;
      DI   <= di_d;
      sel  <= sel_d;
    end
  end

endmodule

// File: tb/tb_irq_vec.sv
// Self-checking bench for irq_vec: directed scenarios plus random bus/source traffic against a behavioural model.
// Two instances share stimulus: default VEC_BASE and VEC_BASE=16'h10FE (low-byte carry case).
module tb_irq_vec;

  localparam logic [15:0] BASE = 16'hFE00;
  localparam logic [15:0] VB0  = 16'hFF00;
  localparam logic [15:0] VB1  = 16'h10FE;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] ab  = '0;
  logic        we  = 1'b0;
  logic [7:0]  dout = '0;
  logic [7:0]  src = '0;
  logic        irq0, irq1, sel0, sel1;
  logic [7:0]  di0, di1;

  int checks = 0;
  int fails  = 0;
  logic [7:0] cur_src = '0;

  // Behavioural model state
  logic [7:0] m_pend = '0, m_mask = '0, m_srcq = '0, m_di0 = '0, m_di1 = '0;
  bit         m_irq = 0, m_sel = 0, m_fetch = 0;
  int         m_vid = 0;

  irq_vec #(.BASE(BASE), .VEC_BASE(VB0), .NSRC(8)) dut (
    .clk(clk), .reset(rst), .AB(ab), .WE(we), .DO(dout), .src(src),
    .irq(irq0), .DI(di0), .sel(sel0)
  );

  irq_vec #(.BASE(BASE), .VEC_BASE(VB1), .NSRC(8)) dut_w (
    .clk(clk), .reset(rst), .AB(ab), .WE(we), .DO(dout), .src(src),
    .irq(irq1), .DI(di1), .sel(sel1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] vbyte(input logic [15:0] vb, input int n, input bit hi);
    int v;
    v = (int'(vb) + 4 * n) % 65536;
    return hi ? 8'(v / 256) : 8'(v % 256);
  endfunction

  // One bus cycle: drive, clock, then advance the model with what was driven.
  task automatic bus(input bit r, input logic [15:0] a, input bit w, input logic [7:0] d,
                     input logic [7:0] s);
    logic [7:0] act, clr, rise;
    int first;
    rst = r; ab = a; we = w; dout = d; src = s;
    @(posedge clk);
    #1;
    if (!r) begin
      m_pend = '0; m_mask = '0; m_irq = 0; m_sel = 0; m_fetch = 0; m_vid = 0;
      m_di0 = '0; m_di1 = '0;
    end else begin
      rise  = s & ~m_srcq;
      act   = m_pend & m_mask;
      first = -1;
      for (int i = 7; i >= 0; i--) if (act[i]) first = i;
      clr   = (w && a == BASE) ? d : 8'h00;
      m_sel = 0; m_di0 = '0; m_di1 = '0;
      if (m_fetch && !w && a == 16'hFFFF) begin
        m_sel = 1;
        m_di0 = vbyte(VB0, m_vid, 1);
        m_di1 = vbyte(VB1, m_vid, 1);
`ifdef IRQ_VEC_AUTOACK_EN
        clr[m_vid] = 1'b1;
`endif
      end else if (!w && a == 16'hFFFE && m_irq) begin
        m_vid = (first < 0) ? 0 : first;
        m_sel = 1;
        m_di0 = vbyte(VB0, m_vid, 0);
        m_di1 = vbyte(VB1, m_vid, 0);
      end else if (!w && a == BASE) begin
        m_sel = 1; m_di0 = m_pend; m_di1 = m_pend;
      end else if (!w && a == BASE + 16'd1) begin
        m_sel = 1; m_di0 = m_mask; m_di1 = m_mask;
      end else if (!w && a == BASE + 16'd2) begin
        m_sel = 1;
        m_di0 = (first < 0) ? 8'h80 : 8'(first);
        m_di1 = m_di0;
      end
      m_fetch = m_sel && !w && a == 16'hFFFE;
      if (w && a == BASE + 16'd1) m_mask = d;
      m_irq  = |act;
      m_pend = (m_pend & ~clr) | rise;
    end
    m_srcq = s;
  endtask

  task automatic idle();
    bus(1, 16'h0000, 0, 8'h00, cur_src);
  endtask

  task automatic rd(input logic [15:0] a);
    bus(1, a, 0, 8'h00, cur_src);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(1, a, 1, d, cur_src);
  endtask

  task automatic test_reset();
    cur_src = 8'h01;
    repeat (3) bus(0, 16'h0000, 0, 8'h00, cur_src);
    checks++; if (sel0 !== 1'b0) begin fails++; $display("FAIL reset_sel: got %0b expected 0", sel0); end
    checks++; if (di0 !== 8'h00) begin fails++; $display("FAIL reset_di: got %h expected 00", di0); end
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL reset_irq: got %0b expected 0", irq0); end
    wr(BASE + 16'd1, 8'hFF);
    repeat (4) begin
      idle();
      checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL reset_release_irq: got %0b expected 0", irq0); end
    end
    rd(BASE);
    checks++; if (di0 !== 8'h00 || sel0 !== 1'b1)
      begin fails++; $display("FAIL reset_status: got %h sel %0b expected 00 sel 1", di0, sel0); end
    cur_src = 8'h00;
    idle();
  endtask

  task automatic test_vector();
    wr(BASE + 16'd1, 8'h0C);
    cur_src = 8'h08; idle();
    cur_src = 8'h00; idle();
    cur_src = 8'h04; idle();
    cur_src = 8'h00; idle(); idle();
    checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL vec_irq: got %0b expected 1", irq0); end
    rd(BASE + 16'd2);
    checks++; if (di0 !== 8'h02) begin fails++; $display("FAIL vec_index: got %h expected 02", di0); end
    rd(16'hFFFE);
    checks++; if (di0 !== 8'h08 || sel0 !== 1'b1)
      begin fails++; $display("FAIL vec_lo: got %h sel %0b expected 08 sel 1", di0, sel0); end
    checks++; if (di1 !== 8'h06) begin fails++; $display("FAIL vec_lo_w: got %h expected 06", di1); end
    rd(16'hFFFF);
    checks++; if (di0 !== 8'hFF || sel0 !== 1'b1)
      begin fails++; $display("FAIL vec_hi: got %h sel %0b expected FF sel 1", di0, sel0); end
    checks++; if (di1 !== 8'h11) begin fails++; $display("FAIL vec_hi_w: got %h expected 11", di1); end
  endtask

  task automatic test_set_wins();
    wr(BASE, 8'hFF);
    bus(1, BASE, 1, 8'h04, 8'h04);
    cur_src = 8'h00;
    rd(BASE);
    checks++; if (di0 !== 8'h04) begin fails++; $display("FAIL set_wins: got %h expected 04", di0); end
  endtask

  task automatic test_abort();
    rd(16'hFFFE);
    checks++; if (sel0 !== 1'b1) begin fails++; $display("FAIL abort_lo_sel: got %0b expected 1", sel0); end
    rd(16'h1234);
    checks++; if (sel0 !== 1'b0) begin fails++; $display("FAIL abort_other_sel: got %0b expected 0", sel0); end
    rd(16'hFFFF);
    checks++; if (sel0 !== 1'b0) begin fails++; $display("FAIL abort_hi_sel: got %0b expected 0", sel0); end
    rd(16'hFFFE);
    checks++; if (sel0 !== 1'b1) begin fails++; $display("FAIL midrst_lo_sel: got %0b expected 1", sel0); end
    bus(0, 16'h0000, 0, 8'h00, cur_src);
    rd(16'hFFFF);
    checks++; if (sel0 !== 1'b0 || di0 !== 8'h00)
      begin fails++; $display("FAIL midrst_hi: got %h sel %0b expected 00 sel 0", di0, sel0); end
  endtask

  task automatic test_wrap();
    bit ack_en;
`ifdef IRQ_VEC_AUTOACK_EN
    ack_en = 1;
`else
    ack_en = 0;
`endif
    wr(BASE + 16'd1, 8'h02);
    cur_src = 8'h02; idle();
    cur_src = 8'h00; idle(); idle();
    checks++; if (irq1 !== 1'b1) begin fails++; $display("FAIL wrap_irq: got %0b expected 1", irq1); end
    rd(16'hFFFE);
    checks++; if (di1 !== 8'h02 || sel1 !== 1'b1)
      begin fails++; $display("FAIL wrap_lo: got %h sel %0b expected 02 sel 1", di1, sel1); end
    checks++; if (di0 !== 8'h04) begin fails++; $display("FAIL wrap_lo_def: got %h expected 04", di0); end
    rd(16'hFFFF);
    checks++; if (di1 !== 8'h11 || sel1 !== 1'b1)
      begin fails++; $display("FAIL wrap_hi: got %h sel %0b expected 11 sel 1", di1, sel1); end
    idle();
    checks++; if (irq1 !== !ack_en) begin fails++; $display("FAIL ack_irq: got %0b expected %0b", irq1, !ack_en); end
    rd(BASE);
    checks++; if (di1 !== (ack_en ? 8'h00 : 8'h02))
      begin fails++; $display("FAIL ack_status: got %h expected %h", di1, ack_en ? 8'h00 : 8'h02); end
  endtask

  task automatic test_idle_fffe();
    wr(BASE, 8'hFF);
    idle(); idle();
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL idle_irq: got %0b expected 0", irq0); end
    rd(16'hFFFE);
    checks++; if (sel0 !== 1'b0 || di0 !== 8'h00)
      begin fails++; $display("FAIL idle_fffe: got %h sel %0b expected 00 sel 0", di0, sel0); end
    wr(BASE + 16'd2, 8'h05);
    rd(BASE + 16'd2);
    checks++; if (di0 !== 8'h80 || sel0 !== 1'b1)
      begin fails++; $display("FAIL index_ro: got %h sel %0b expected 80 sel 1", di0, sel0); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    bit          w, r;
    logic [7:0]  d;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + 16'($urandom_range(0, 3));
        3:       a = 16'hFFFE;
        4:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      w = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 60) != 0);
      d = 8'($urandom);
      if ($urandom_range(0, 2) == 0) cur_src = 8'($urandom);
      bus(r, a, w, d, cur_src);
      checks++; if (irq0 !== m_irq) begin fails++; $display("FAIL rnd_irq[%0d]: got %0b expected %0b", n, irq0, m_irq); end
      checks++; if (sel0 !== m_sel) begin fails++; $display("FAIL rnd_sel[%0d]: got %0b expected %0b", n, sel0, m_sel); end
      checks++; if (di0 !== m_di0) begin fails++; $display("FAIL rnd_di[%0d]: got %h expected %h", n, di0, m_di0); end
      checks++; if (sel1 !== m_sel) begin fails++; $display("FAIL rnd_sel_w[%0d]: got %0b expected %0b", n, sel1, m_sel); end
      checks++; if (di1 !== m_di1) begin fails++; $display("FAIL rnd_di_w[%0d]: got %h expected %h", n, di1, m_di1); end
    end
  endtask

  initial begin
    test_reset();
    test_vector();
    test_set_wins();
    test_abort();
    test_wrap();
    test_idle_fffe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
